digi_pattern_src: RTL and testbench
===================================

// Module: digi_pattern_src
// PURPOSE
//   Clocked digital stimulus sequencer. Plays a stored bit pattern with a
//   programmable dwell per bit and emits a level code for the Amp input stage.
//   Mirrors the qucsator DigiSource (init level plus switching times) in
//   synthesizable form. Lives with the lumped-component mappings.
// PARAMETERS
//   DEPTH    8      pattern entries, >=1
//   DW       16     dwell counter width (cycles per entry)
//   OUT_W    12     output level code width
//   VHIGH    12'hFFF  code emitted for bit=1
//   VLOW     12'h000  code emitted for bit=0
//   INIT_BIT 0      idle level bit (DigiSource init)
// PORTS
//   clk         in   1      clock, rising edge
//   rst         in   1      synchronous reset, active-high
//   load_valid  in   1      pattern entry offered
//   load_ready  out  1      entry accepted when valid&ready
//   load_bit    in   1      entry level
//   load_dwell  in   DW     entry duration in cycles; 0 is treated as 1
//   clear       in   1      empty the pattern store (IDLE only)
//   start       in   1      begin playback
//   stop        in   1      abort playback
//   loop_en     in   1      wrap to entry 0 after the last entry
//   busy        out  1      high in RUN
//   done        out  1      one-cycle pulse on normal completion
//   bit_idx     out  clog2(DEPTH)  index of the entry currently driven
//   out_code    out  OUT_W  registered level code
// BEHAVIOUR
//   - Reset: state=IDLE, wr_ptr=0, busy=0, done=0, bit_idx=0,
//     out_code=INIT_BIT?VHIGH:VLOW. Reset mid-run aborts at once.
//     The pattern store is not wiped; wr_ptr=0 makes it logically empty.
//   - Store: DEPTH x {bit, dwell}. load_ready = (state==IDLE) && (wr_ptr<DEPTH) && !clear.
//     Each accepted entry writes store[wr_ptr] and increments wr_ptr.
//     n = wr_ptr. clear in IDLE sets wr_ptr=0. clear in RUN is ignored.
//   - States: IDLE, RUN. No other states.
//   - IDLE->RUN when start && !stop && n>0. Otherwise start is ignored.
//     On the transition: idx=0, cnt=max(dwell[0],1)-1.
//     out_code = level(store[0]) from the next cycle (1-cycle latency).
//   - In RUN, each cycle:
//     - if cnt!=0: cnt decrements.
//     - else, if idx<n-1: idx++ and cnt reloads from the next entry.
//     - else, with loop_en: idx=0 and cnt reloads from entry 0.
//     - else: go to IDLE, pulse done for 1 cycle,
//       out_code returns to the INIT level in that same cycle.
//   - Entry k drives out_code for exactly max(dwell_k,1) consecutive cycles.
//     There are no gap cycles between entries or across a loop wrap.
//   - loop_en is sampled at the end of the last entry. Deasserting it
//     mid-pass ends playback after the current pass.
//   - stop in RUN: next cycle is IDLE, out_code=INIT level, busy=0, no done.
//     stop takes priority over the natural end in the same cycle.
//   - start while in RUN is ignored. start and stop together in IDLE: stays IDLE.
//   - busy=1 exactly on the cycles where out_code shows pattern data.
//     bit_idx tracks idx while in RUN and is 0 in IDLE.
//   - Arithmetic: dwell counter is unsigned DW bits and never wraps.
//     wr_ptr saturates at DEPTH.
// TESTING
//   1. Load {1,2},{0,3},{1,1}, INIT_BIT=0, pulse start at cycle 0.
//      -> out_code FFF,FFF,000,000,000,FFF on cycles 1-6; 000 from cycle 7.
//      -> done=1 only at cycle 7.
//   2. Load a single {1,0} entry and start.
//      -> exactly one FFF cycle, then done.
//   3. Pattern from test 1 with loop_en=1 for 14 cycles.
//      -> period of 6 with seamless wrap; drop loop_en and playback ends after the pass.
//   4. stop at cycle 3 of test 1.
//      -> cycle 4 out=000, busy=0, done never asserts.
//   5. Offer 10 entries with DEPTH=8.
//      -> 8 accepted, load_ready=0 afterwards.
//      -> start with n=0 after clear: stays IDLE.
//   6. rst during RUN.
//      -> next cycle IDLE, out=INIT code; a subsequent start is ignored until reload.

Source files
------------

// File: rtl/digi_pattern_src.sv
// digi_pattern_src
//   Clocked digital stimulus sequencer. A small store of {bit, dwell} entries
//   is loaded while idle. On start the entries play back in order, each for
//   max(dwell,1) cycles, optionally wrapping to entry 0. The level code is
//   registered: VHIGH for a 1 bit, VLOW for a 0 bit, and the INIT level
//   whenever the sequencer is idle.
//
// Load handshake: an entry transfers on a rising clk edge where
// load_valid && load_ready are both high. load_valid may be raised at any
// time. load_ready is high only in IDLE, with room left in the store and
// no clear request this cycle. The store never stalls a transfer once
// both signals are high.
module digi_pattern_src #(
  parameter int               DEPTH    = 8,
  parameter int               DW       = 16,
  parameter int               OUT_W    = 12,
  parameter logic [OUT_W-1:0] VHIGH    = 12'hFFF,
  parameter logic [OUT_W-1:0] VLOW     = 12'h000,
  parameter bit               INIT_BIT = 1'b0,
  localparam int              IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int              PW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             load_bit,
  input  logic [DW-1:0]    load_dwell,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  output logic             busy,
  output logic             done,
  output logic [IW-1:0]    bit_idx,
  output logic [OUT_W-1:0] out_code,
  output logic             dbg_state
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [OUT_W-1:0] INIT_CODE = INIT_BIT ? VHIGH : VLOW;

  // Pattern store: not reset, wr_ptr alone defines how many entries are valid.
  logic          bit_mem   [DEPTH];
  logic [DW-1:0] dwell_mem [DEPTH];

  state_t           state_q, state_d;
  logic [PW-1:0]    wr_ptr_q;
  logic [IW-1:0]    idx_q, idx_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [OUT_W-1:0] out_code_q, out_code_d;

  logic             load_fire;
  logic [IW-1:0]    idx_next;
  logic             more_entries;

  // Counter value that makes an entry last max(dwell,1) cycles.
  function automatic logic [DW-1:0] reload_of(input logic [DW-1:0] d);
    return (d == '0) ? '0 : d - DW'(1);
  endfunction

  function automatic logic [OUT_W-1:0] level_of(input logic b);
    return b ? VHIGH : VLOW;
  endfunction

  assign load_ready = (state_q == ST_IDLE) && (wr_ptr_q < PW'(DEPTH)) && !clear;
  assign load_fire  = load_valid && load_ready;

  // Index of the following entry and whether the current one is not the last.
  assign idx_next     = idx_q + IW'(1);
  assign more_entries = (PW'(idx_q) + PW'(1)) < wr_ptr_q;

  // Store write port: one entry per accepted load.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      bit_mem[IW'(wr_ptr_q)]   <= load_bit;
      dwell_mem[IW'(wr_ptr_q)] <= load_dwell;
    end
  end

  // Write pointer: cleared by reset or an idle clear, saturates at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
    end else if ((state_q == ST_IDLE) && clear) begin
      wr_ptr_q <= '0;
    end else if (load_fire) begin
      wr_ptr_q <= wr_ptr_q + PW'(1);
    end
  end

  // Next-state, entry index, dwell counter and done pulse.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (start && !stop && (wr_ptr_q != '0)) begin
          state_d = ST_RUN;
          idx_d   = '0;
          cnt_d   = reload_of(dwell_mem[0]);
        end
      end
      ST_RUN: begin
        if (stop) begin
          // Abort wins over a natural end in the same cycle; no done.
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DW'(1);
        end else if (more_entries) begin
          idx_d = idx_next;
          cnt_d = reload_of(dwell_mem[idx_next]);
        end else if (loop_en) begin
          idx_d = '0;
          cnt_d = reload_of(dwell_mem[0]);
        end else begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Level code for the cycle after this edge, from the entry about to be shown.
  always_comb begin
    out_code_d = INIT_CODE;
    if (state_d == ST_RUN) begin
      out_code_d = level_of(bit_mem[idx_d]);
    end
  end

  // Sequencer registers; reset aborts playback immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      out_code_q <= INIT_CODE;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      out_code_q <= out_code_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;
  assign bit_idx   = busy ? idx_q : '0;
  assign out_code  = out_code_q;
  assign dbg_state = (state_q == ST_RUN);

endmodule

// File: tb/tb_digi_pattern_src.sv
// Bench for digi_pattern_src: directed pattern tests plus randomized
// playback, compared every cycle against a pass-list model of the player.
module tb_digi_pattern_src;

  localparam int DEPTH = 8;
  localparam int DW    = 16;
  localparam int OUT_W = 12;
  localparam int IW    = 3;
  localparam logic [OUT_W-1:0] HI = 12'hFFF;
  localparam logic [OUT_W-1:0] LO = 12'h000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             load_valid = 1'b0;
  logic             load_ready;
  logic             load_bit = 1'b0;
  logic [DW-1:0]    load_dwell = '0;
  logic             clear = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             loop_en = 1'b0;
  logic             busy;
  logic             done;
  logic [IW-1:0]    bit_idx;
  logic [OUT_W-1:0] out_code;
  logic             dbg_state;

  digi_pattern_src #(
    .DEPTH(DEPTH), .DW(DW), .OUT_W(OUT_W),
    .VHIGH(HI), .VLOW(LO), .INIT_BIT(1'b0)
  ) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_bit(load_bit), .load_dwell(load_dwell),
    .clear(clear), .start(start), .stop(stop), .loop_en(loop_en),
    .busy(busy), .done(done), .bit_idx(bit_idx),
    .out_code(out_code), .dbg_state(dbg_state)
  );

  // ---------------- behavioural model ----------------
  // The store as plain arrays; a running pass is a list of per-cycle
  // {code, index} samples, head = what the output shows right now.
  int          cyc = 0;
  int          m_wr = 0;
  bit          m_bit [DEPTH];
  int          m_dw  [DEPTH];
  bit          m_run = 1'b0;
  bit          m_done = 1'b0;
  logic [OUT_W-1:0] q_code[$];
  int          q_idx[$];

  task automatic build_pass();
    q_code.delete();
    q_idx.delete();
    for (int k = 0; k < m_wr; k++) begin
      for (int r = 0; r < ((m_dw[k] == 0) ? 1 : m_dw[k]); r++) begin
        q_code.push_back(m_bit[k] ? HI : LO);
        q_idx.push_back(k);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_run = 1'b0; m_wr = 0; m_done = 1'b0;
        q_code.delete(); q_idx.delete();
      end else if (m_run) begin
        m_done = 1'b0;
        if (stop) begin
          m_run = 1'b0;
          q_code.delete(); q_idx.delete();
        end else begin
          void'(q_code.pop_front());
          void'(q_idx.pop_front());
          if (q_code.size() == 0) begin
            if (loop_en) build_pass();
            else begin
              m_run  = 1'b0;
              m_done = 1'b1;
            end
          end
        end
      end else begin
        int n_old;
        m_done = 1'b0;
        n_old  = m_wr;
        if (clear) m_wr = 0;
        else if (load_valid && m_wr < DEPTH) begin
          m_bit[m_wr] = load_bit;
          m_dw[m_wr]  = int'(load_dwell);
          m_wr++;
        end
        if (start && !stop && n_old > 0) begin
          m_run = 1'b1;
          build_pass();
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int tmo_cnt = 0;
  int tmo_seen = 0;
  int lit_id = 0;
  int lit_base = 0;
  logic [OUT_W-1:0] t1_code [0:8];
  initial begin
    t1_code[0] = LO; t1_code[1] = HI; t1_code[2] = HI; t1_code[3] = LO;
    t1_code[4] = LO; t1_code[5] = LO; t1_code[6] = HI; t1_code[7] = LO;
    t1_code[8] = LO;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (tmo_cnt != tmo_seen) begin
        n_tests++;
        n_fail++;
        $display("FAIL timeout: busy still 1, expected 0 within budget (cycle %0d)", cyc);
        tmo_seen = tmo_cnt;
      end
      if (chk_en) begin
        int rel;
        // Per-cycle model comparison.
        chk("out_code", 32'(out_code), m_run ? 32'(q_code[0]) : 32'(LO));
        chk("bit_idx", 32'(bit_idx), m_run ? 32'(q_idx[0]) : 32'd0);
        chk("busy", 32'(busy), 32'(m_run));
        chk("done", 32'(done), 32'(m_done));
        chk("dbg_state", 32'(dbg_state), 32'(m_run));
        chk("load_ready", 32'(load_ready), 32'(!m_run && m_wr < DEPTH && !clear));
        // Hand-computed expectations for the directed tests.
        rel = cyc - lit_base;
        case (lit_id)
          1: if (rel >= 1 && rel <= 8) begin
               chk("t1_code", 32'(out_code), 32'(t1_code[rel]));
               chk("t1_done", 32'(done), 32'(rel == 7));
             end
          2: if (rel == 1) chk("t2_hi", 32'(out_code), 32'hFFF);
             else if (rel == 2) begin
               chk("t2_lo", 32'(out_code), 32'h000);
               chk("t2_done", 32'(done), 32'd1);
             end
          3: if (rel == 7 || rel == 12) chk("t3_hi", 32'(out_code), 32'hFFF);
             else if (rel == 9) chk("t3_idx1", 32'(bit_idx), 32'd1);
             else if (rel == 13) chk("t3_wrap_busy", 32'(busy), 32'd1);
          4: if (rel == 4) begin
               chk("t4_out", 32'(out_code), 32'h000);
               chk("t4_busy", 32'(busy), 32'd0);
             end else if (rel > 4 && rel <= 9) chk("t4_nodone", 32'(done), 32'd0);
          5: if (rel >= 1 && rel <= 3) chk("t5_idle", 32'(busy), 32'd0);
          default: ;
        endcase
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_entry(input logic b, input int d);
    load_valid = 1'b1; load_bit = b; load_dwell = DW'(d);
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic start_pulse(input int id);
    lit_id   = id;
    lit_base = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_t1();
    do_clear();
    load_entry(1'b1, 2);
    load_entry(1'b0, 3);
    load_entry(1'b1, 1);
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) tmo_cnt++;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Test 1: basic three-entry pattern.
    load_t1();
    start_pulse(1);
    repeat (9) tick();

    // Test 2: single entry with zero dwell.
    do_clear();
    load_entry(1'b1, 0);
    start_pulse(2);
    repeat (4) tick();

    // Test 3: looping playback, then loop_en dropped.
    load_t1();
    loop_en = 1'b1;
    start_pulse(3);
    repeat (13) tick();
    loop_en = 1'b0;
    wait_idle(40);

    // Test 4: stop during cycle 3.
    start_pulse(4);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (8) tick();

    // Test 5: overfill the store, then start on an empty store.
    lit_id = 0;
    do_clear();
    load_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      load_bit = 1'($urandom_range(0, 1));
      load_dwell = DW'($urandom_range(0, 3));
      tick();
    end
    load_valid = 1'b0;
    tick();
    do_clear();
    start_pulse(5);
    repeat (4) tick();

    // Test 6: reset mid-run, then start with nothing loaded.
    lit_id = 0;
    load_t1();
    start_pulse(0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start_pulse(0);
    repeat (4) tick();

    // Randomized playback with interfering inputs.
    for (int it = 0; it < 40; it++) begin
      int n;
      int run_len;
      do_clear();
      n = $urandom_range(1, DEPTH);
      for (int k = 0; k < n; k++) load_entry(1'($urandom_range(0, 1)), $urandom_range(0, 4));
      loop_en = ($urandom_range(0, 2) == 0);
      start_pulse(0);
      run_len = $urandom_range(1, 40);
      for (int c = 0; c < run_len; c++) begin
        start      = ($urandom_range(0, 7) == 0);
        stop       = ($urandom_range(0, 29) == 0);
        load_valid = ($urandom_range(0, 7) == 0);
        load_bit   = 1'($urandom_range(0, 1));
        load_dwell = DW'($urandom_range(0, 4));
        tick();
      end
      start = 1'b0; stop = 1'b0; load_valid = 1'b0; loop_en = 1'b0;
      wait_idle(200);
      tick();
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
